// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the write/read FSM state
// encodings used by the slave wrapper.
package axi_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_REQ  = 2'd1,
      R_RESP = 2'd2
   } rd_state_t;

endpackage

// File: rtl/axi_lite_req_timer.sv
// Request watchdog: counts cycles a user request waits for its acknowledge
// and flags expiry on the last permitted cycle. TIMEOUT_CYCLES=0 disables it.
module axi_lite_req_timer #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_WIDTH      = 9
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [CNT_WIDTH-1:0] cnt_q;

   // Counter holds zero while cleared and advances once per un-acked request cycle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         assign expire = enable && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
      end else begin : g_no_timeout
         assign expire = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/axi_lite_slave_wrapper.sv
// AXI4-Lite slave endpoint. Each AXI write/read becomes a held request on the
// user port; the user acknowledge (or a timeout) produces the AXI response.
// Handshakes: a transfer happens on an aclk edge where valid and ready are
// both 1; valid-side payload must stay stable until that edge, and ready
// never depends combinationally on valid.
module axi_lite_slave_wrapper
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STRB_WIDTH     = 4,
   parameter int RESP_WIDTH     = 2,
   parameter int PROT_WIDTH     = 3,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_WIDTH      = 9
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  s_axi_awvalid,
   output logic                  s_axi_awready,
   input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic [PROT_WIDTH-1:0] s_axi_awprot,
   input  logic                  s_axi_wvalid,
   output logic                  s_axi_wready,
   input  logic [DATA_WIDTH-1:0] s_axi_wdata,
   input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
   output logic                  s_axi_bvalid,
   input  logic                  s_axi_bready,
   output logic [RESP_WIDTH-1:0] s_axi_bresp,
   input  logic                  s_axi_arvalid,
   output logic                  s_axi_arready,
   input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic [PROT_WIDTH-1:0] s_axi_arprot,
   output logic                  s_axi_rvalid,
   input  logic                  s_axi_rready,
   output logic [DATA_WIDTH-1:0] s_axi_rdata,
   output logic [RESP_WIDTH-1:0] s_axi_rresp,
   output logic                  u_wr_req,
   output logic [ADDR_WIDTH-1:0] u_wr_addr,
   output logic [DATA_WIDTH-1:0] u_wr_data,
   output logic [STRB_WIDTH-1:0] u_wr_strb,
   input  logic                  u_wr_ack,
   input  logic                  u_wr_err,
   output logic                  u_rd_req,
   output logic [ADDR_WIDTH-1:0] u_rd_addr,
   input  logic                  u_rd_ack,
   input  logic [DATA_WIDTH-1:0] u_rd_data,
   input  logic                  u_rd_err,
   output logic [1:0]            wr_state_dbg,
   output logic [1:0]            rd_state_dbg
);

   wr_state_t wr_state, wr_next;
   rd_state_t rd_state, rd_next;
   logic      live_q;
   logic      aw_done_q, w_done_q;
   logic      aw_hs, w_hs, ar_hs;
   logic      wr_expire, rd_expire;
   logic      unused_prot;

   // Protection bits are accepted but carry no meaning for this endpoint.
   assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   assign wr_state_dbg = wr_state;
   assign rd_state_dbg = rd_state;

   // Keeps readies low until the first edge after reset release.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) live_q <= 1'b0;
      else          live_q <= 1'b1;
   end

   // Write FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) wr_state <= W_IDLE;
      else          wr_state <= wr_next;
   end

   // Write FSM next state: request once both AW and W are held, respond on ack or expiry.
   always_comb begin
      wr_next = wr_state;
      case (wr_state)
         W_IDLE:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) wr_next = W_REQ;
         W_REQ:   if (u_wr_ack || wr_expire) wr_next = W_RESP;
         W_RESP:  if (s_axi_bready) wr_next = W_IDLE;
         default: wr_next = W_IDLE;
      endcase
   end

   // Write FSM outputs: independent AW/W readies, held request, response valid.
   always_comb begin
      s_axi_awready = live_q && (wr_state == W_IDLE) && !aw_done_q;
      s_axi_wready  = live_q && (wr_state == W_IDLE) && !w_done_q;
      u_wr_req      = (wr_state == W_REQ);
      s_axi_bvalid  = (wr_state == W_RESP);
   end

   // Write datapath: capture AW and W separately, latch bresp when the request ends.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         u_wr_addr   <= '0;
         u_wr_data   <= '0;
         u_wr_strb   <= '0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         s_axi_bresp <= '0;
      end else begin
         if (aw_hs) u_wr_addr <= s_axi_awaddr;
         if (w_hs) begin
            u_wr_data <= s_axi_wdata;
            u_wr_strb <= s_axi_wstrb;
         end
         if ((wr_state == W_IDLE) && (wr_next == W_REQ)) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
         end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
         end
         if (wr_state == W_REQ) begin
            if (u_wr_ack)       s_axi_bresp <= RESP_WIDTH'(u_wr_err ? RESP_SLVERR : RESP_OKAY);
            else if (wr_expire) s_axi_bresp <= RESP_WIDTH'(RESP_SLVERR);
         end
      end
   end

   // Read FSM state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rd_state <= R_IDLE;
      else          rd_state <= rd_next;
   end

   // Read FSM next state: request after AR, respond on ack or expiry.
   always_comb begin
      rd_next = rd_state;
      case (rd_state)
         R_IDLE:  if (ar_hs) rd_next = R_REQ;
         R_REQ:   if (u_rd_ack || rd_expire) rd_next = R_RESP;
         R_RESP:  if (s_axi_rready) rd_next = R_IDLE;
         default: rd_next = R_IDLE;
      endcase
   end

   // Read FSM outputs.
   always_comb begin
      s_axi_arready = live_q && (rd_state == R_IDLE);
      u_rd_req      = (rd_state == R_REQ);
      s_axi_rvalid  = (rd_state == R_RESP);
   end

   // Read datapath: capture address, latch data/response when the request ends.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         u_rd_addr   <= '0;
         s_axi_rdata <= '0;
         s_axi_rresp <= '0;
      end else begin
         if (ar_hs) u_rd_addr <= s_axi_araddr;
         if (rd_state == R_REQ) begin
            if (u_rd_ack) begin
               s_axi_rdata <= u_rd_data;
               s_axi_rresp <= RESP_WIDTH'(u_rd_err ? RESP_SLVERR : RESP_OKAY);
            end else if (rd_expire) begin
               s_axi_rdata <= '0;
               s_axi_rresp <= RESP_WIDTH'(RESP_SLVERR);
            end
         end
      end
   end

   axi_lite_req_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_wr_timer (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (wr_state != W_REQ),
      .enable  ((wr_state == W_REQ) && !u_wr_ack),
      .expire  (wr_expire)
   );

   axi_lite_req_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_rd_timer (
      .aclk    (aclk),
      .aresetn (aresetn),
      .clear   (rd_state != R_REQ),
      .enable  ((rd_state == R_REQ) && !u_rd_ack),
      .expire  (rd_expire)
   );

endmodule

// File: tb/tb_axi_lite_slave_wrapper.sv
// Bench for axi_lite_slave_wrapper: directed scenarios plus randomized
// transactions against a word-memory model of the user peripheral.
module tb_axi_lite_slave_wrapper;

   localparam int TO = 8;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        s_axi_awvalid = 0, s_axi_awready;
   logic [31:0] s_axi_awaddr = 0;
   logic [2:0]  s_axi_awprot = 0;
   logic        s_axi_wvalid = 0, s_axi_wready;
   logic [31:0] s_axi_wdata = 0;
   logic [3:0]  s_axi_wstrb = 0;
   logic        s_axi_bvalid, s_axi_bready = 0;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_arvalid = 0, s_axi_arready;
   logic [31:0] s_axi_araddr = 0;
   logic [2:0]  s_axi_arprot = 0;
   logic        s_axi_rvalid, s_axi_rready = 0;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        u_wr_req;
   logic [31:0] u_wr_addr, u_wr_data;
   logic [3:0]  u_wr_strb;
   logic        u_wr_ack = 0, u_wr_err = 0;
   logic        u_rd_req;
   logic [31:0] u_rd_addr;
   logic        u_rd_ack = 0, u_rd_err = 0;
   logic [31:0] u_rd_data = 0;
   logic [1:0]  wr_state_dbg, rd_state_dbg;

   int          total = 0;
   int          bad = 0;
   logic [33:0] exp_q[$];
   logic [31:0] model_mem[8];
   logic [31:0] periph_mem[8];
   logic [146:0] all_out;

   assign all_out = {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp,
                     s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
                     u_wr_req, u_wr_addr, u_wr_data, u_wr_strb,
                     u_rd_req, u_rd_addr, wr_state_dbg, rd_state_dbg};

   // clock / reset
   always #5 aclk = ~aclk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   axi_lite_slave_wrapper #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .RESP_WIDTH(2),
      .PROT_WIDTH(3), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(4)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .u_wr_req(u_wr_req), .u_wr_addr(u_wr_addr), .u_wr_data(u_wr_data), .u_wr_strb(u_wr_strb),
      .u_wr_ack(u_wr_ack), .u_wr_err(u_wr_err),
      .u_rd_req(u_rd_req), .u_rd_addr(u_rd_addr),
      .u_rd_ack(u_rd_ack), .u_rd_data(u_rd_data), .u_rd_err(u_rd_err),
      .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
   );

   // Byte-lane merge used by both the model and the peripheral storage.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // One AXI write with its user-side acknowledge. delay > TO-1 means no ack.
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_off, input int w_off,
                           input int delay, input bit err, input int bdelay,
                           input string name);
      bit          aw_t = 0, w_t = 0, hs_aw, hs_w, timed_out;
      int          k = 0, req_cycles = 0;
      logic [1:0]  exp_resp, got_resp;
      logic [33:0] exp_item;
      timed_out = (delay > TO - 1);
      exp_resp  = (err || timed_out) ? SLVERR : OKAY;
      exp_q.push_back({exp_resp, 32'h0});
      if (bdelay < 0) s_axi_bready = 1'b1;
      while (!(aw_t && w_t) && k < 20) begin
         s_axi_awvalid = !aw_t && (k >= aw_off);
         s_axi_awaddr  = addr;
         s_axi_wvalid  = !w_t && (k >= w_off);
         s_axi_wdata   = data;
         s_axi_wstrb   = strb;
         if (w_t && !aw_t) begin
            total++;
            if (s_axi_wready !== 1'b0 || u_wr_req !== 1'b0) begin
               bad++;
               $display("FAIL %s wait_aw: wready=%b u_wr_req=%b required 0/0", name, s_axi_wready, u_wr_req);
            end
         end
         hs_aw = s_axi_awvalid && s_axi_awready;
         hs_w  = s_axi_wvalid && s_axi_wready;
         tick();
         aw_t = aw_t | hs_aw;
         w_t  = w_t | hs_w;
         k++;
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      total++;
      if (!(aw_t && w_t)) begin
         bad++;
         $display("FAIL %s aw_w_accept: aw=%b w=%b required 1/1 within 20 cycles", name, aw_t, w_t);
      end
      total++;
      if (u_wr_req !== 1'b1 || u_wr_addr !== addr || u_wr_data !== data || u_wr_strb !== strb) begin
         bad++;
         $display("FAIL %s wr_payload: req=%b addr=%h data=%h strb=%h required 1 %h %h %h",
                  name, u_wr_req, u_wr_addr, u_wr_data, u_wr_strb, addr, data, strb);
      end
      while (u_wr_req === 1'b1 && req_cycles < 12) begin
         if (!timed_out && req_cycles == delay) begin
            u_wr_ack = 1'b1;
            u_wr_err = err;
            if (!err) periph_mem[u_wr_addr[4:2]] = merge(periph_mem[u_wr_addr[4:2]], u_wr_data, u_wr_strb);
         end
         tick();
         u_wr_ack = 1'b0;
         u_wr_err = 1'b0;
         req_cycles++;
      end
      total++;
      if (req_cycles != (timed_out ? TO : delay + 1)) begin
         bad++;
         $display("FAIL %s wr_req_len: got %0d cycles required %0d", name, req_cycles, timed_out ? TO : delay + 1);
      end
      total++;
      if (s_axi_bvalid !== 1'b1) begin
         bad++;
         $display("FAIL %s bvalid_rise: bvalid=%b required 1", name, s_axi_bvalid);
      end
      got_resp = s_axi_bresp;
      if (bdelay >= 0) begin
         if (timed_out) u_wr_ack = 1'b1;
         for (int j = 0; j < bdelay; j++) begin
            tick();
            u_wr_ack = 1'b0;
            total++;
            if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== got_resp) begin
               bad++;
               $display("FAIL %s b_hold: bvalid=%b bresp=%b required 1 %b", name, s_axi_bvalid, s_axi_bresp, got_resp);
            end
         end
         s_axi_bready = 1'b1;
      end
      tick();
      s_axi_bready = 1'b0;
      u_wr_ack = 1'b0;
      total++;
      if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b1) begin
         bad++;
         $display("FAIL %s b_done: bvalid=%b awready=%b wready=%b required 0 1 1",
                  name, s_axi_bvalid, s_axi_awready, s_axi_wready);
      end
      exp_item = exp_q.pop_front();
      total++;
      if (got_resp !== exp_item[33:32]) begin
         bad++;
         $display("FAIL %s bresp: got %b required %b", name, got_resp, exp_item[33:32]);
      end
      if (exp_resp == OKAY) model_mem[addr[4:2]] = merge(model_mem[addr[4:2]], data, strb);
   endtask

   // One AXI read with its user-side acknowledge. delay > TO-1 means no ack.
   task automatic do_read(input logic [31:0] addr, input int delay, input bit err,
                          input int rdelay, input string name);
      bit          ar_t = 0, hs, timed_out;
      int          k = 0, req_cycles = 0;
      logic [33:0] got, exp_item;
      timed_out = (delay > TO - 1);
      exp_q.push_back({(err || timed_out) ? SLVERR : OKAY, timed_out ? 32'h0 : model_mem[addr[4:2]]});
      if (rdelay < 0) s_axi_rready = 1'b1;
      while (!ar_t && k < 20) begin
         s_axi_arvalid = 1'b1;
         s_axi_araddr  = addr;
         hs = s_axi_arready;
         tick();
         ar_t = hs;
         k++;
      end
      s_axi_arvalid = 1'b0;
      total++;
      if (!ar_t || u_rd_req !== 1'b1 || u_rd_addr !== addr || s_axi_arready !== 1'b0) begin
         bad++;
         $display("FAIL %s rd_req: accepted=%b req=%b addr=%h arready=%b required 1 1 %h 0",
                  name, ar_t, u_rd_req, u_rd_addr, s_axi_arready, addr);
      end
      while (u_rd_req === 1'b1 && req_cycles < 12) begin
         if (!timed_out && req_cycles == delay) begin
            u_rd_ack  = 1'b1;
            u_rd_err  = err;
            u_rd_data = periph_mem[u_rd_addr[4:2]];
         end else begin
            u_rd_data = $urandom();
         end
         tick();
         u_rd_ack = 1'b0;
         u_rd_err = 1'b0;
         req_cycles++;
      end
      total++;
      if (req_cycles != (timed_out ? TO : delay + 1)) begin
         bad++;
         $display("FAIL %s rd_req_len: got %0d cycles required %0d", name, req_cycles, timed_out ? TO : delay + 1);
      end
      total++;
      if (s_axi_rvalid !== 1'b1) begin
         bad++;
         $display("FAIL %s rvalid_rise: rvalid=%b required 1", name, s_axi_rvalid);
      end
      got = {s_axi_rresp, s_axi_rdata};
      if (rdelay >= 0) begin
         if (timed_out) begin
            u_rd_ack  = 1'b1;
            u_rd_data = 32'hBAD0_BAD0;
         end
         for (int j = 0; j < rdelay; j++) begin
            tick();
            u_rd_ack = 1'b0;
            total++;
            if (s_axi_rvalid !== 1'b1 || {s_axi_rresp, s_axi_rdata} !== got || s_axi_arready !== 1'b0) begin
               bad++;
               $display("FAIL %s r_hold: rvalid=%b resp_data=%h arready=%b required 1 %h 0",
                        name, s_axi_rvalid, {s_axi_rresp, s_axi_rdata}, s_axi_arready, got);
            end
         end
         s_axi_rready = 1'b1;
      end
      tick();
      s_axi_rready = 1'b0;
      u_rd_ack = 1'b0;
      total++;
      if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
         bad++;
         $display("FAIL %s r_done: rvalid=%b arready=%b required 0 1", name, s_axi_rvalid, s_axi_arready);
      end
      exp_item = exp_q.pop_front();
      total++;
      if (got !== exp_item) begin
         bad++;
         $display("FAIL %s rresp_rdata: got %h required %h", name, got, exp_item);
      end
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      #12;
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got %h required 0", all_out);
      end
      @(posedge aclk);
      #3;
      aresetn = 1'b1;
      #1;
      total++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b000) begin
         bad++;
         $display("FAIL reset_release_readies: got %b required 000", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
      tick();
      total++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
         bad++;
         $display("FAIL first_edge_readies: got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
   endtask

   task automatic test_write_same_cycle();
      do_write(32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 1, 1'b0, 0, "same_cycle");
   endtask

   task automatic test_w_before_aw();
      do_write(32'h0000_2004, 32'hCAFE_F00D, 4'h3, 3, 0, 0, 1'b0, 1, "w_first");
      do_write(32'h0000_2008, 32'h0BAD_F00D, 4'hC, 0, 2, 3, 1'b0, 0, "aw_first");
   endtask

   task automatic test_read_backpressure();
      model_mem[0]  = 32'h1234_5678;
      periph_mem[0] = 32'h1234_5678;
      do_read(32'h0000_3000, 1, 1'b0, 4, "rd_backpressure");
   endtask

   task automatic test_read_timeout();
      do_read(32'h0000_3004, 9, 1'b0, 2, "rd_timeout");
      do_read(32'h0000_3004, TO - 1, 1'b0, 0, "rd_ack_at_expiry");
   endtask

   task automatic test_write_timeout();
      do_write(32'h0000_1010, 32'h5555_AAAA, 4'hF, 0, 0, 9, 1'b0, 2, "wr_timeout");
      do_write(32'h0000_1014, 32'h7777_8888, 4'hF, 0, 0, TO - 1, 1'b0, 0, "wr_ack_at_expiry");
   endtask

   task automatic test_early_ready();
      do_write(32'h0000_1018, 32'h0102_0304, 4'h5, 1, 0, 0, 1'b0, -1, "bready_early");
      do_read(32'h0000_1018, 2, 1'b0, -1, "rready_early");
   endtask

   task automatic test_write_err_with_read();
      logic [33:0] exp_item;
      total++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
         bad++;
         $display("FAIL par_readies: got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
      end
      s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_1008;
      s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'hFFFF_0000; s_axi_wstrb = 4'hF;
      s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_100C;
      exp_q.push_back({OKAY, model_mem[3]});
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      total++;
      if (u_wr_req !== 1'b1 || u_rd_req !== 1'b1) begin
         bad++;
         $display("FAIL par_reqs: wr_req=%b rd_req=%b required 1 1", u_wr_req, u_rd_req);
      end
      u_wr_ack = 1'b1; u_wr_err = 1'b1;
      u_rd_ack = 1'b1; u_rd_err = 1'b0; u_rd_data = periph_mem[u_rd_addr[4:2]];
      tick();
      u_wr_ack = 1'b0; u_wr_err = 1'b0; u_rd_ack = 1'b0;
      total++;
      if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== SLVERR) begin
         bad++;
         $display("FAIL par_bresp: bvalid=%b bresp=%b required 1 10", s_axi_bvalid, s_axi_bresp);
      end
      exp_item = exp_q.pop_front();
      total++;
      if (s_axi_rvalid !== 1'b1 || {s_axi_rresp, s_axi_rdata} !== exp_item) begin
         bad++;
         $display("FAIL par_read: rvalid=%b resp_data=%h required 1 %h", s_axi_rvalid, {s_axi_rresp, s_axi_rdata}, exp_item);
      end
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;
      tick();
      s_axi_bready = 1'b0; s_axi_rready = 1'b0;
      total++;
      if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0) begin
         bad++;
         $display("FAIL par_done: bvalid=%b rvalid=%b required 0 0", s_axi_bvalid, s_axi_rvalid);
      end
   endtask

   task automatic test_reset_midflight();
      s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_1004;
      s_axi_wvalid  = 1'b1; s_axi_wdata  = 32'h1111_2222; s_axi_wstrb = 4'hF;
      s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_1000;
      tick();
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
      u_rd_ack = 1'b1; u_rd_data = 32'h9999_9999;
      tick();
      u_rd_ack = 1'b0;
      total++;
      if (u_wr_req !== 1'b1 || s_axi_rvalid !== 1'b1) begin
         bad++;
         $display("FAIL midflight_setup: wr_req=%b rvalid=%b required 1 1", u_wr_req, s_axi_rvalid);
      end
      #2;
      aresetn = 1'b0;
      #1;
      total++;
      if (all_out !== '0) begin
         bad++;
         $display("FAIL midflight_reset_outputs: got %h required 0", all_out);
      end
      @(posedge aclk);
      @(posedge aclk);
      #3;
      aresetn = 1'b1;
      tick();
      total++;
      if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, wr_state_dbg, rd_state_dbg} !== 9'b111_00_0000) begin
         bad++;
         $display("FAIL midflight_idle: got %b required 111000000",
                  {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, wr_state_dbg, rd_state_dbg});
      end
      do_write(32'h0000_1004, 32'h3333_4444, 4'hF, 0, 0, 0, 1'b0, 0, "post_reset_wr");
      do_read(32'h0000_1004, 0, 1'b0, 0, "post_reset_rd");
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         logic [31:0] addr;
         int          delay, bd;
         bit          err;
         addr  = $urandom();
         delay = $urandom_range(0, 9);
         err   = ($urandom_range(0, 3) == 0);
         bd    = int'($urandom_range(0, 4)) - 1;
         if ($urandom_range(0, 1) == 1)
            do_write(addr, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 2),
                     $urandom_range(0, 2), delay, err, bd, "rand_wr");
         else
            do_read(addr, delay, err, bd, "rand_rd");
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) begin
         model_mem[i]  = $urandom();
         periph_mem[i] = model_mem[i];
      end
      test_reset();
      test_write_same_cycle();
      test_w_before_aw();
      test_read_backpressure();
      test_read_timeout();
      test_write_timeout();
      test_early_ready();
      test_write_err_with_read();
      test_reset_midflight();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_wrapper.md
Name: axi_lite_slave_wrapper

Overview:
AXI4-Lite slave endpoint that terminates an AXI-Lite bus and converts each transaction into a request/acknowledge pair on a simple user register/memory port. It is the counterpart to the AXI master wrapper and sits in front of peripherals and register banks on the RV32I AXI interconnect. Write and read paths are independent, with one outstanding transaction per direction. An optional acknowledge timeout returns SLVERR when the user side stalls.

Parameters:
ADDR_WIDTH, 32, address width of AXI and user ports
DATA_WIDTH, 32, data width
STRB_WIDTH, 4, write strobe width (DATA_WIDTH/8)
RESP_WIDTH, 2, response width
PROT_WIDTH, 3, AxPROT width (accepted, ignored)
TIMEOUT_CYCLES, 256, cycles to wait for user ack before SLVERR; 0 disables the timeout
CNT_WIDTH, 9, timeout counter width (must hold TIMEOUT_CYCLES)

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous reset, active-low
s_axi_awvalid/s_axi_awready  in/out  1  AW handshake
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awprot  in  PROT_WIDTH  ignored
s_axi_wvalid/s_axi_wready  in/out  1  W handshake
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  STRB_WIDTH  byte strobes
s_axi_bvalid/s_axi_bready  out/in  1  B handshake
s_axi_bresp  out  RESP_WIDTH  write response
s_axi_arvalid/s_axi_arready  in/out  1  AR handshake
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arprot  in  PROT_WIDTH  ignored
s_axi_rvalid/s_axi_rready  out/in  1  R handshake
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  RESP_WIDTH  read response
u_wr_req  out  1  write request, held until ack
u_wr_addr/u_wr_data/u_wr_strb  out  ADDR/DATA/STRB_WIDTH  registered write payload
u_wr_ack  in  1  write done, sampled only while u_wr_req=1
u_wr_err  in  1  write error, qualified by u_wr_ack
u_rd_req  out  1  read request, held until ack
u_rd_addr  out  ADDR_WIDTH  registered read address
u_rd_ack  in  1  read data valid, sampled only while u_rd_req=1
u_rd_data  in  DATA_WIDTH  read data, qualified by u_rd_ack
u_rd_err  in  1  read error, qualified by u_rd_ack

Behaviour:
- Reset (aresetn low, asynchronous): every output is 0, including all readies. FSMs enter IDLE. Readies rise on the first aclk edge after reset release.
- Write FSM states: W_IDLE, W_REQ, W_RESP.
  - W_IDLE: awready=1 until AW is captured; wready=1 until W is captured. AW and W may arrive in either order or in the same cycle. Each is captured into its own register and its ready drops after capture.
  - When both AW and W are captured, go to W_REQ: u_wr_req=1 with registered addr, data and strb.
  - Minimum latency: AW and W handshake at edge T gives u_wr_req high in cycle T+1.
  - W_REQ: when u_wr_ack=1 on an edge, latch bresp (u_wr_err ? SLVERR 2'b10 : OKAY 2'b00), drop u_wr_req, go to W_RESP. bvalid rises the next cycle. An ack in the first cycle of req is legal.
  - W_RESP: hold bvalid and bresp stable until bready=1. Then return to W_IDLE and raise both readies the next cycle.
- Read FSM states: R_IDLE, R_REQ, R_RESP.
  - R_IDLE: arready=1. On the AR handshake, capture araddr, drop arready, go to R_REQ.
  - R_REQ: u_rd_req=1. On u_rd_ack, latch u_rd_data into rdata and set rresp (u_rd_err ? SLVERR : OKAY). Go to R_RESP.
  - R_RESP: hold rvalid, rdata and rresp stable until rready=1, then return to R_IDLE.
- Timeout (TIMEOUT_CYCLES>0): a per-direction counter clears on entry to *_REQ and increments each cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: drop req, respond SLVERR (rdata=0 for reads), go to *_RESP.
  - An ack in the same cycle as expiry wins.
  - A late ack outside *_REQ is ignored.
- Read and write paths never block each other. Simultaneous AW, W and AR in one cycle are all accepted.
- bready or rready held high before valid: complete in the first valid cycle.
- AxPROT and address alignment are not checked. Every address is forwarded.

Decomposition:
- Shared package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - write and read FSM state encodings
- Sub-module axi_lite_req_timer: clear/enable/expire counter, parameterised by TIMEOUT_CYCLES and CNT_WIDTH. Instantiated once for write and once for read.

Test Plan:
- AW and W in the same cycle, addr=0x1000, data=0xDEADBEEF, strb=0xF, ack after 2 cycles -> u_wr_req high 2 cycles with matching payload; bvalid with bresp=00 one cycle after ack.
- W three cycles before AW (addr=0x2004, strb=0x3) -> wready drops after W capture; u_wr_req only after AW; payload intact; bresp=00.
- AR addr=0x3000, ack with u_rd_data=0x12345678 and rready low for 4 cycles -> rvalid and rdata=0x12345678 stable all 4 cycles; arready=0 until completion.
- TIMEOUT_CYCLES=8, no u_rd_ack -> u_rd_req drops after 8 cycles; rresp=10, rdata=0; a late ack is ignored.
- u_wr_ack with u_wr_err=1 -> bresp=10. A simultaneous read (AR in the same cycle as AW and W) completes independently with OKAY.
- aresetn asserted while in W_REQ and R_RESP -> all outputs 0 immediately; after release both FSMs are in IDLE and accept a fresh write and read.
